gelato_warp_activate_arbiter: RTL

Collects warp re-activation requests from several producers (decode/branch resolution, scoreboard release, memory writeback) and serialises them into the single `activate_valid`/`activate_warp_num` channel that re-enables a warp in the fetch scheduler. Each producer gets a small FIFO. A round-robin arbiter drains at most one request per cycle, so no activation is ever lost when several arrive in the same cycle.

---
 rtl/gelato_warp_activate_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/gelato_warp_activate_arbiter.sv
// rtl/gelato_warp_activate_arbiter.sv - per-producer FIFOs merged round-robin into one warp activation channel
// Optional GELATO_ACT_DEDUP_EN discards requests for warps that are already queued.

module gelato_act_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W:0]    count;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
endmodule

module gelato_warp_activate_arbiter #(
   parameter int NUM_SRC    = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int WARP_NUM_W = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rdy,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC*WARP_NUM_W-1:0] src_warp_num,
   output logic [NUM_SRC-1:0]            src_ready,
   output logic                          activate_valid,
   output logic [WARP_NUM_W-1:0]         activate_warp_num,
   output logic                          idle
);
   localparam int LG_W = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0]    fifo_full;
   logic [NUM_SRC-1:0]    fifo_empty;
   logic [NUM_SRC-1:0]    accept;
   logic [NUM_SRC-1:0]    store;
   logic [NUM_SRC-1:0]    pop;
   logic [WARP_NUM_W-1:0] head [NUM_SRC];

   logic [LG_W-1:0]       last_grant;
   logic [LG_W-1:0]       win_idx;
   logic [LG_W-1:0]       cand_idx;
   logic                  win_found;
   logic [WARP_NUM_W-1:0] win_warp;
   int                    cand;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fifo
      gelato_act_fifo #(
         .DEPTH  (FIFO_DEPTH),
         .DATA_W (WARP_NUM_W)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (store[gi]),
         .push_data (src_warp_num[gi*WARP_NUM_W +: WARP_NUM_W]),
         .pop       (pop[gi]),
         .head      (head[gi]),
         .full      (fifo_full[gi]),
         .empty     (fifo_empty[gi])
      );
   end

   // No pop-through: a full FIFO stays not-ready even in the cycle it is popped.
   assign src_ready = {NUM_SRC{rdy}} & ~fifo_full;
   assign accept    = src_valid & src_ready;

   // Round-robin search starting just after the previous winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_warp  = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand     = (int'(last_grant) + k) % NUM_SRC;
         cand_idx = LG_W'(cand);
         if (!win_found && !fifo_empty[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
            win_warp  = head[cand_idx];
         end
      end
   end

   always_comb begin
      pop = '0;
      if (rdy && win_found) begin
         pop[win_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant        <= LG_W'(NUM_SRC - 1);
         activate_valid    <= 1'b0;
         activate_warp_num <= '0;
      end else if (rdy) begin
         if (win_found) begin
            activate_valid    <= 1'b1;
            activate_warp_num <= win_warp;
            last_grant        <= win_idx;
         end else begin
            activate_valid    <= 1'b0;
         end
      end
   end

   assign idle = (&fifo_empty) & ~activate_valid;

`ifdef GELATO_ACT_DEDUP_EN
   localparam int NUM_WARPS = 2**WARP_NUM_W;

   logic [NUM_WARPS-1:0] pending;
   logic [NUM_WARPS-1:0] pending_live;
   logic [NUM_WARPS-1:0] pending_next;
   logic [NUM_SRC-1:0]   dup;

   // A warp popped this edge is no longer pending, so a same-edge push of it is kept.
   always_comb begin
      pending_live = pending;
      if (rdy && win_found) begin
         pending_live[win_warp] = 1'b0;
      end
      dup = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (pending_live[src_warp_num[i*WARP_NUM_W +: WARP_NUM_W]]) begin
            dup[i] = 1'b1;
         end
         for (int j = 0; j < i; j++) begin
            if (accept[j] &&
                src_warp_num[j*WARP_NUM_W +: WARP_NUM_W] == src_warp_num[i*WARP_NUM_W +: WARP_NUM_W]) begin
               dup[i] = 1'b1;
            end
         end
      end
      pending_next = pending_live;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (store[i]) begin
            pending_next[src_warp_num[i*WARP_NUM_W +: WARP_NUM_W]] = 1'b1;
         end
      end
   end

   assign store = accept & ~dup;

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end
`else
   assign store = accept;
`endif
endmodule
